jesd204b_tx_link: RTL

// - JESD204B transmit link layer, counterpart of the RX core: drives L GT TX lanes at 4 octets/lane/clk.
// - Generates CGS, 4-multiframe ILAS, then user data; sequencing by sync_ni handshake and SYSREF-aligned LMFC.
// - Sits between the sample packer (tx_data_i) and GT TX ports (gtx_data_o/gtx_charisk_o).

---
 rtl/jesd204b_tx_pkg.sv | 33 +++
 rtl/jesd204b_tx_lmfc.sv | 40 ++++
 rtl/jesd204b_tx_link.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/jesd204b_tx_pkg.sv
// Shared constants, link state encoding and the ILAS octet generator
// for the JESD204B transmit link layer.
package jesd204b_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code group (CGS)
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows
  localparam int ILAS_MF = 4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CGS   = 2'd1,
    ST_ILAS  = 2'd2,
    ST_DATA  = 2'd3
  } tx_state_e;

  // Returns {charisk, octet} for octet o of ILAS multiframe mf.
  // cfg must already hold this lane's LID and FCHK.
  function automatic logic [8:0] ilas_octet(input logic [15:0]  o,
                                            input logic [15:0]  o_last,
                                            input logic [1:0]   mf,
                                            input logic [111:0] cfg);
    logic [3:0] ci;
    ci = o[3:0] - 4'd2;
    if (o == 16'd0)                        return {1'b1, K28_0};
    else if (o == o_last)                  return {1'b1, K28_3};
    else if (mf == 2'd1 && o == 16'd1)     return {1'b1, K28_4};
    else if (mf == 2'd1 && o < 16'd16)     return {1'b0, cfg[{ci, 3'b000} +: 8]};
    else                                   return {1'b0, o[7:0]};
  endfunction

endpackage

// File: rtl/jesd204b_tx_lmfc.sv
// SYSREF synchroniser with rising-edge detect and the LMFC beat counter.
// beat_nxt is the value the counter takes at the coming clock edge.
module jesd204b_tx_lmfc
  import jesd204b_tx_pkg::*;
#(
  parameter int BEATS = 32,
  parameter int BW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sysref_i,
  output logic [BW-1:0] beat_nxt,
  output logic          sysref_edge,
  output logic          lmfc_clk_o
);

  // [0],[1] synchroniser stages, [2] previous synchronised value
  logic [2:0]    sysref_sr;
  logic [BW-1:0] beat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sysref_sr   <= '0;
      sysref_edge <= 1'b0;
      beat        <= '0;
      lmfc_clk_o  <= 1'b0;
    end else begin
      sysref_sr   <= {sysref_sr[1:0], sysref_i};
      sysref_edge <= sysref_sr[1] & ~sysref_sr[2];
      beat        <= beat_nxt;
      lmfc_clk_o  <= (beat_nxt == '0);
    end
  end

  always_comb begin
    beat_nxt = beat + BW'(1);
    if (sysref_edge || beat == BW'(BEATS - 1)) beat_nxt = '0;
  end

endmodule

// File: rtl/jesd204b_tx_link.sv
// JESD204B TX link layer: CGS, 4-multiframe ILAS and user data on L lanes,
// 4 octets per lane per clock, first octet in time at bits [7:0] of a lane.
module jesd204b_tx_link
  import jesd204b_tx_pkg::*;
#(
  parameter int L          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int F          = 4,
  parameter int K          = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sysref_i,
  input  logic                    sync_ni,
  input  logic                    gtx_ready_i,
  input  logic [111:0]            cfg_octets_i,
  input  logic [DATA_WIDTH*L-1:0] tx_data_i,
  output logic                    tx_ready_o,
  output logic [DATA_WIDTH*L-1:0] gtx_data_o,
  output logic [4*L-1:0]          gtx_charisk_o,
  output logic                    lmfc_clk_o,
  output logic [1:0]              state_o
);

  localparam int OCTETS_MF = F * K;
  localparam int BEATS     = OCTETS_MF / 4;
  localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

  tx_state_e             state, state_nxt;
  logic [1:0]            mf, mf_nxt;
  logic                  sync_m, sync_s, sync_lo_q;
  logic                  resync;
  logic [BW-1:0]         beat_nxt;
  logic                  sysref_edge;
  logic [DATA_WIDTH*L-1:0] ilas_data;
  logic [4*L-1:0]        ilas_k;

  jesd204b_tx_lmfc #(.BEATS(BEATS), .BW(BW)) u_lmfc (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sysref_i    (sysref_i),
    .beat_nxt    (beat_nxt),
    .sysref_edge (sysref_edge),
    .lmfc_clk_o  (lmfc_clk_o)
  );

  assign state_o = state;

  // SYNC~ resets to 0 so a fresh link always starts by requesting sync
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_m    <= 1'b0;
      sync_s    <= 1'b0;
      sync_lo_q <= 1'b1;
    end else begin
      sync_m    <= sync_ni;
      sync_s    <= sync_m;
      sync_lo_q <= ~sync_s;
    end
  end

  assign resync = ~sync_s & sync_lo_q & (state == ST_ILAS || state == ST_DATA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_RESET;
      mf    <= '0;
    end else begin
      state <= state_nxt;
      mf    <= mf_nxt;
    end
  end

  // Transitions land on the edge where the LMFC counter becomes 0, so the
  // first /R/ and the first user word coincide with lmfc_clk_o.
  always_comb begin
    state_nxt = state;
    mf_nxt    = mf;
    case (state)
      ST_RESET: if (gtx_ready_i) state_nxt = ST_CGS;
      ST_CGS: begin
        if (sync_s && beat_nxt == '0) begin
          state_nxt = ST_ILAS;
          mf_nxt    = '0;
        end
      end
      ST_ILAS: begin
        if (sysref_edge) begin
          mf_nxt = '0;
        end else if (beat_nxt == '0) begin
          if (mf == 2'(ILAS_MF - 1)) state_nxt = ST_DATA;
          else                       mf_nxt    = mf + 2'd1;
        end
      end
      default: ;
    endcase
    if (resync)       state_nxt = ST_CGS;
    if (!gtx_ready_i) state_nxt = ST_RESET;
  end

  for (genvar l = 0; l < L; l++) begin : g_lane
    logic [111:0] cfg_lid;
    logic [111:0] cfg_lane;
    logic [7:0]   fchk;

    always_comb begin
      cfg_lid        = cfg_octets_i;
      cfg_lid[28:24] = 5'(l);
      fchk           = '0;
      for (int n = 0; n < 13; n++) fchk = fchk + cfg_lid[8*n +: 8];
    end

    assign cfg_lane = {fchk, cfg_lid[103:0]};

    for (genvar j = 0; j < 4; j++) begin : g_oct
      logic [8:0] ko;
      assign ko = ilas_octet(16'(beat_nxt) * 16'd4 + 16'(j), 16'(OCTETS_MF - 1),
                             mf_nxt, cfg_lane);
      assign ilas_data[DATA_WIDTH*l + 8*j +: 8] = ko[7:0];
      assign ilas_k[4*l + j]                    = ko[8];
    end
  end

  // tx_ready_o is high in every cycle whose gtx_data_o carries user data;
  // tx_data_i is taken on each rising edge that enters or stays in DATA.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gtx_data_o    <= '0;
      gtx_charisk_o <= '0;
      tx_ready_o    <= 1'b0;
    end else begin
      tx_ready_o <= (state_nxt == ST_DATA);
      case (state_nxt)
        ST_CGS: begin
          gtx_data_o    <= {(DATA_WIDTH*L/8){K28_5}};
          gtx_charisk_o <= '1;
        end
        ST_ILAS: begin
          gtx_data_o    <= ilas_data;
          gtx_charisk_o <= ilas_k;
        end
        ST_DATA: begin
          gtx_data_o    <= tx_data_i;
          gtx_charisk_o <= '0;
        end
        default: begin
          gtx_data_o    <= '0;
          gtx_charisk_o <= '0;
        end
      endcase
    end
  end

endmodule
